// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcode/funct
// constants, mux-select encodings and the decoded-instruction record.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_JAL = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  typedef struct packed {
    logic       legal;
    logic       use_mem;
    logic       is_sw;
    logic       is_beq;
    logic       is_jr;
    logic       is_jal;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake plus control strobes/selects leaving the controller;
// master is the controller, slave is the datapath/memory side.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic        mem_req;
  logic        mem_ack;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        ALUSrc;
  logic        MemWrite;
  logic [2:0]  NPCOp;
  logic [1:0]  EXTOp;
  logic [1:0]  RegDst;
  logic [1:0]  ALUOp;
  logic [1:0]  MemtoReg;
  logic        instr_done;
  logic        illegal;
  logic [31:0] instr_cnt;

  modport master (
    output mem_req, PCWrite, IRWrite, RegWrite, ALUSrc, MemWrite,
    output NPCOp, EXTOp, RegDst, ALUOp, MemtoReg,
    output instr_done, illegal, instr_cnt,
    input  mem_ack
  );

  modport slave (
    input  mem_req, PCWrite, IRWrite, RegWrite, ALUSrc, MemWrite,
    input  NPCOp, EXTOp, RegDst, ALUOp, MemtoReg,
    input  instr_done, illegal, instr_cnt,
    output mem_ack
  );

endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational opcode/funct decode into path flags and the
// datapath select fields used by the controller FSM.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            dec.legal   = 1'b1;
            dec.reg_dst = RD_RD;
            dec.alu_op  = ALU_ADD;
          end
          FN_SUB: begin
            dec.legal   = 1'b1;
            dec.reg_dst = RD_RD;
            dec.alu_op  = ALU_SUB;
          end
          FN_JR: begin
            dec.legal = 1'b1;
            dec.is_jr = 1'b1;
          end
          default: dec.legal = 1'b0;
        endcase
      end
      OP_ORI: begin
        dec.legal   = 1'b1;
        dec.alu_src = 1'b1;
        dec.ext_op  = EXT_ZERO;
        dec.alu_op  = ALU_OR;
      end
      // lui places imm<<16 on the B input; rs is $0 so OR passes it through
      OP_LUI: begin
        dec.legal   = 1'b1;
        dec.alu_src = 1'b1;
        dec.ext_op  = EXT_LUI;
        dec.alu_op  = ALU_OR;
      end
      OP_LW: begin
        dec.legal      = 1'b1;
        dec.use_mem    = 1'b1;
        dec.alu_src    = 1'b1;
        dec.ext_op     = EXT_SIGN;
        dec.alu_op     = ALU_ADD;
        dec.mem_to_reg = M2R_MEM;
      end
      OP_SW: begin
        dec.legal   = 1'b1;
        dec.use_mem = 1'b1;
        dec.is_sw   = 1'b1;
        dec.alu_src = 1'b1;
        dec.ext_op  = EXT_SIGN;
        dec.alu_op  = ALU_ADD;
      end
      OP_BEQ: begin
        dec.legal  = 1'b1;
        dec.is_beq = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_JAL: begin
        dec.legal      = 1'b1;
        dec.is_jal     = 1'b1;
        dec.reg_dst    = RD_RA;
        dec.mem_to_reg = M2R_PC;
      end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: 5-state FSM, shared-memory handshake
// and retired-instruction counter. Decode is delegated to ctrl_decode.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemWrite,
  output logic [2:0]  NPCOp,
  output logic [1:0]  EXTOp,
  output logic [1:0]  RegDst,
  output logic [1:0]  ALUOp,
  output logic [1:0]  MemtoReg,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg;
  dec_t        dec;

  ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (instr_done) cnt_reg <= cnt_reg + 32'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    MemWrite   = 1'b0;
    NPCOp      = NPC_PC4;
    EXTOp      = EXT_ZERO;
    RegDst     = RD_RT;
    ALUOp      = ALU_ADD;
    MemtoReg   = M2R_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    // A low reset silences every strobe so an in-flight instruction is dropped
    if (reset) begin
      case (state_reg)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            NPCOp      = NPC_PC4;
            state_next = DECODE;
          end
        end
        DECODE: begin
          if (!dec.legal) begin
            illegal    = 1'b1;
            state_next = FETCH;
          end else if (dec.is_jal) begin
            state_next = WB;
          end else begin
            state_next = EXEC;
          end
        end
        EXEC: begin
          EXTOp  = dec.ext_op;
          ALUSrc = dec.alu_src;
          ALUOp  = dec.alu_op;
          if (dec.is_beq) begin
            PCWrite    = zero;
            NPCOp      = zero ? NPC_BEQ : NPC_PC4;
            instr_done = 1'b1;
            state_next = FETCH;
          end else if (dec.is_jr) begin
            PCWrite    = 1'b1;
            NPCOp      = NPC_JR;
            instr_done = 1'b1;
            state_next = FETCH;
          end else if (dec.use_mem) begin
            state_next = MEM;
          end else begin
            state_next = WB;
          end
        end
        MEM: begin
          mem_req  = 1'b1;
          EXTOp    = dec.ext_op;
          ALUSrc   = dec.alu_src;
          ALUOp    = dec.alu_op;
          MemWrite = dec.is_sw;
          if (mem_ack) begin
            if (dec.is_sw) begin
              instr_done = 1'b1;
              state_next = FETCH;
            end else begin
              state_next = WB;
            end
          end
        end
        WB: begin
          EXTOp      = dec.ext_op;
          ALUSrc     = dec.alu_src;
          ALUOp      = dec.alu_op;
          RegWrite   = 1'b1;
          RegDst     = dec.reg_dst;
          MemtoReg   = dec.mem_to_reg;
          instr_done = 1'b1;
          state_next = FETCH;
          if (dec.is_jal) begin
            PCWrite = 1'b1;
            NPCOp   = NPC_JAL;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  assign instr_cnt = reset ? cnt_reg : 32'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle control-vector checks
// plus a retire/illegal scoreboard checked against the counter.
module tb_multicycle_ctrl;

  typedef logic [18:0] cvec_t;
  typedef struct {
    logic        ill;
    logic [31:0] cnt;
  } sb_t;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_cnt;
  sb_t         sb[$];
  cvec_t       f_ack, idle, zv;
  cvec_t       seq[$];

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_req    (bus.mem_req),
    .mem_ack    (bus.mem_ack),
    .PCWrite    (bus.PCWrite),
    .IRWrite    (bus.IRWrite),
    .RegWrite   (bus.RegWrite),
    .ALUSrc     (bus.ALUSrc),
    .MemWrite   (bus.MemWrite),
    .NPCOp      (bus.NPCOp),
    .EXTOp      (bus.EXTOp),
    .RegDst     (bus.RegDst),
    .ALUOp      (bus.ALUOp),
    .MemtoReg   (bus.MemtoReg),
    .instr_done (bus.instr_done),
    .illegal    (bus.illegal),
    .instr_cnt  (bus.instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // {mem_req, PCWrite, IRWrite, RegWrite, ALUSrc, MemWrite, NPCOp, EXTOp, RegDst, ALUOp, MemtoReg, done, illegal}
  function automatic cvec_t cv(input logic mreq, pcw, irw, rw, asrc, mw,
                               input logic [2:0] npc, input logic [1:0] ext, rd, aop, m2r,
                               input logic done, ill);
    return {mreq, pcw, irw, rw, asrc, mw, npc, ext, rd, aop, m2r, done, ill};
  endfunction

  function automatic cvec_t dut_cv();
    return {bus.mem_req, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.ALUSrc, bus.MemWrite,
            bus.NPCOp, bus.EXTOp, bus.RegDst, bus.ALUOp, bus.MemtoReg, bus.instr_done, bus.illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts at a negedge in idle FETCH; cycle i drives mem_ack=ack_mask[i] and expects seq[i].
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic [7:0] ack_mask,
                           input cvec_t exp_seq[$], input bit retire);
    sb_t e;
    opcode = op;
    funct  = fn;
    zero   = z;
    if (retire) exp_cnt = exp_cnt + 32'd1;
    e.ill = !retire;
    e.cnt = exp_cnt;
    sb.push_back(e);
    for (int i = 0; i < exp_seq.size(); i++) begin
      bus.mem_ack = ack_mask[i];
      #1;
      check($sformatf("%s_c%0d", tag, i), 32'(dut_cv()), 32'(exp_seq[i]));
      step();
    end
    bus.mem_ack = 1'b0;
    #1;
    check({tag, "_fetch"}, 32'(dut_cv()), 32'(idle));
    check({tag, "_cnt"}, bus.instr_cnt, exp_cnt);
  endtask

  // Scoreboard: every retire/illegal pulse pops one expectation; count checked next cycle.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && (bus.instr_done || bus.illegal)) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_kind", 32'(bus.illegal), 32'(e.ill));
          @(negedge clk);
          #2;
          check("sb_cnt", bus.instr_cnt, e.cnt);
          $display("txn %s instr_cnt=%h", e.ill ? "illegal" : "retire ", bus.instr_cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_cnt = '0;
    reset = 1'b0;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    bus.mem_ack = 1'b0;
    f_ack = cv(1,1,1,0,0,0,3'd0,2'd0,2'd0,2'd0,2'd0,0,0);
    idle  = cv(1,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,2'd0,0,0);
    zv    = '0;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_outputs", 32'(dut_cv()), 32'(zv));
    check("rst_cnt", bus.instr_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_fetch", 32'(dut_cv()), 32'(idle));
    check("rst_cnt_after", bus.instr_cnt, 32'd0);

    seq = '{f_ack, zv, zv, cv(0,0,0,1,0,0,3'd0,2'd0,2'd1,2'd0,2'd0,1,0)};
    run_instr("add", 6'h00, 6'h20, 1'b0, 8'b0000_1111, seq, 1'b1);

    seq = '{f_ack, zv, cv(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd1,2'd0,0,0),
            cv(0,0,0,1,0,0,3'd0,2'd0,2'd1,2'd1,2'd0,1,0)};
    run_instr("sub", 6'h00, 6'h22, 1'b0, 8'b0000_0001, seq, 1'b1);

    seq = '{f_ack, zv, cv(0,0,0,0,1,0,3'd0,2'd0,2'd0,2'd2,2'd0,0,0),
            cv(0,0,0,1,1,0,3'd0,2'd0,2'd0,2'd2,2'd0,1,0)};
    run_instr("ori", 6'h0D, 6'h00, 1'b0, 8'b0000_0001, seq, 1'b1);

    seq = '{f_ack, zv, cv(0,0,0,0,1,0,3'd0,2'd1,2'd0,2'd0,2'd0,0,0),
            cv(1,0,0,0,1,0,3'd0,2'd1,2'd0,2'd0,2'd0,0,0),
            cv(1,0,0,0,1,0,3'd0,2'd1,2'd0,2'd0,2'd0,0,0),
            cv(1,0,0,0,1,0,3'd0,2'd1,2'd0,2'd0,2'd0,0,0),
            cv(0,0,0,1,1,0,3'd0,2'd1,2'd0,2'd0,2'd1,1,0)};
    run_instr("lw", 6'h23, 6'h00, 1'b0, 8'b0010_0001, seq, 1'b1);

    seq = '{f_ack, zv, cv(0,0,0,0,1,0,3'd0,2'd1,2'd0,2'd0,2'd0,0,0),
            cv(1,0,0,0,1,1,3'd0,2'd1,2'd0,2'd0,2'd0,0,0),
            cv(1,0,0,0,1,1,3'd0,2'd1,2'd0,2'd0,2'd0,1,0)};
    run_instr("sw", 6'h2B, 6'h00, 1'b0, 8'b0001_0001, seq, 1'b1);

    seq = '{f_ack, zv, cv(0,1,0,0,0,0,3'd1,2'd0,2'd0,2'd1,2'd0,1,0)};
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 8'b0000_0001, seq, 1'b1);

    seq = '{f_ack, zv, cv(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd1,2'd0,1,0)};
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 8'b0000_0001, seq, 1'b1);

    seq = '{f_ack, zv, cv(0,1,0,0,0,0,3'd3,2'd0,2'd0,2'd0,2'd0,1,0)};
    run_instr("jr", 6'h00, 6'h08, 1'b0, 8'b0000_0001, seq, 1'b1);

    seq = '{f_ack, cv(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,2'd0,0,1)};
    run_instr("ill_op", 6'h3F, 6'h00, 1'b0, 8'b0000_0001, seq, 1'b0);

    seq = '{f_ack, cv(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,2'd0,0,1)};
    run_instr("ill_fn", 6'h00, 6'h3F, 1'b0, 8'b0000_0001, seq, 1'b0);

    // sw abandoned by reset while waiting in MEM
    opcode = 6'h2B;
    funct  = 6'h00;
    bus.mem_ack = 1'b1;
    #1;
    check("swrst_fetch", 32'(dut_cv()), 32'(f_ack));
    step();
    bus.mem_ack = 1'b0;
    step();
    step();
    #1;
    check("swrst_memwait", 32'(dut_cv()), 32'(cv(1,0,0,0,1,1,3'd0,2'd1,2'd0,2'd0,2'd0,0,0)));
    step();
    reset = 1'b0;
    #1;
    check("swrst_outputs", 32'(dut_cv()), 32'(zv));
    step();
    reset = 1'b1;
    exp_cnt = '0;
    #1;
    check("swrst_after", 32'(dut_cv()), 32'(idle));
    check("swrst_cnt", bus.instr_cnt, 32'd0);

    // preload the counter to its maximum, then let jal retire and wrap it
    force dut.cnt_reg = 32'hFFFF_FFFF;
    step();
    release dut.cnt_reg;
    exp_cnt = 32'hFFFF_FFFF;
    step();
    #1;
    check("preload_cnt", bus.instr_cnt, exp_cnt);

    seq = '{f_ack, zv, cv(0,1,0,1,0,0,3'd2,2'd0,2'd2,2'd0,2'd2,1,0)};
    run_instr("jal_wrap", 6'h03, 6'h00, 1'b0, 8'b0000_0001, seq, 1'b1);
    check("wrap_cnt", bus.instr_cnt, 32'd0);

    step();
    step();
    step();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
